sbox_share_ctrl: RTL and testbench
==================================

# sbox_share_ctrl

Time-multiplexed S-box controller. It shares `LANES` combinational `sbox` instances between two requesters: the round datapath (128-bit SubBytes) and the key-expansion unit (32-bit SubWord). It replaces the 16+4 parallel S-box instances with a small lane bank that is reused over several cycles. Each requester has a valid/ready input handshake and a valid/ready output handshake. Only one operation is in flight at a time.

## Interface
- `LANES`, default 4: number of `sbox` instances. Legal values are 1, 2, 4, 8, 16; any other value is a compile-time error.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `st_valid`  in  1  round-datapath request valid.
- `st_ready`  out  1  round request accepted when `st_valid & st_ready` at a clock edge.
- `st_data`  in  128  state input; byte i = `st_data[8i+7:8i]`.
- `st_out_valid`  out  1  SubBytes result valid.
- `st_out_ready`  in  1  consumer accepts the SubBytes result.
- `st_out_data`  out  128  SubBytes result; byte i = S(input byte i).
- `kw_valid`  in  1  key-word request valid.
- `kw_ready`  out  1  key-word request accepted on handshake.
- `kw_data`  in  32  word input; byte j = `kw_data[8j+7:8j]`.
- `kw_out_valid`  out  1  SubWord result valid.
- `kw_out_ready`  in  1  consumer accepts the SubWord result.
- `kw_out_data`  out  32  SubWord result; byte j = S(input byte j).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ST_RUN, KW_RUN, ST_HOLD, KW_HOLD.
- Pass counts: P_st = 16/LANES; P_kw = max(1, 4/LANES). Pass counter width is log2(P_st), minimum 1 bit.
- IDLE:
  - `kw_ready = 1`.
  - `st_ready = ~kw_valid`. The key word has fixed priority because the round needs its key.
  - On a handshake: latch the data into the operand register, clear the pass counter and the result register, and go to ST_RUN or KW_RUN.
- ST_RUN:
  - Pass k feeds operand bytes k·LANES … k·LANES+LANES-1 to lanes 0…LANES-1.
  - The lane outputs are written to the same byte positions of the result register.
  - After pass P_st-1, go to ST_HOLD.
- KW_RUN:
  - Same scheme over bytes 0–3.
  - When LANES > 4, only lanes 0–3 are used and the unused lane inputs are driven to 0.
  - After pass P_kw-1, go to KW_HOLD.
- ST_HOLD / KW_HOLD:
  - The matching `*_out_valid` is high and `*_out_data` holds the result register.
  - Both output values stay stable until the output handshake.
  - On the handshake, go to IDLE.
- Both `*_ready` signals are 0 in every state except IDLE. New requests wait while an operation runs or holds.
- `*_out_data` reflects the result register in all states. It is meaningful only while the matching `*_out_valid` is high.
- Requesters may drop valid before the handshake; nothing is latched without a handshake.
- The S-box function is identical to the AES forward S-box, implemented by the team's `sbox` module.

## Timing
- Acceptance edge E0. Pass k is evaluated in the cycle after E_k and captured at E_{k+1}.
- `*_out_valid` rises immediately after edge E_P (P = P_st or P_kw). Latency is P cycles: 4 cycles for SubBytes and 1 for SubWord when LANES=4.
- If `*_out_ready` is already high, the output handshake occurs at E_{P+1}. `*_ready` is high in the following cycle.
- Back-to-back throughput is one operation per P+2 cycles.
- Reset, whether asserted idle or mid-operation, takes effect immediately and asynchronously:
  - state returns to IDLE; pass counter, operand and result registers clear to 0;
  - `st_out_valid = kw_out_valid = busy = 0` and `*_out_data = 0`;
  - `st_ready = ~kw_valid` and `kw_ready = 1` once reset is deasserted;
  - an in-flight operation is discarded and produces no output.
- Simultaneous `st_valid` and `kw_valid` in IDLE: KW is accepted; ST is accepted on the first IDLE cycle in which `kw_valid = 0`.
- Output handshake and a new request in the same cycle: the new request is not accepted in that cycle, because the block is still in HOLD.

## Test plan
- Reset, then `st_data = 128'h0f0e0d0c0b0a09080706050403020100`:
  - `st_out_data = 128'h76abd7fe2b670130c56f6bf27b777c63`;
  - with LANES=4, `st_out_valid` is high exactly 4 cycles after acceptance.
- `kw_data = 32'h09cf4f3c` → `kw_out_data = 32'h018a84eb`; `kw_out_valid` is high 1 cycle after acceptance (LANES=4).
- Both valids asserted in IDLE, with `st_data = 0` and `kw_data = 32'h00000053`:
  - `32'h636363ed` is returned first;
  - then `128'h63636363636363636363636363636363`;
  - `st_ready` stays low until the KW HOLD→IDLE transition.
- Hold `st_out_ready = 0` for 10 cycles after `st_out_valid`:
  - `st_out_valid` and `st_out_data` remain stable;
  - `st_ready` and `kw_ready` stay 0 throughout.
- Assert `rst` on the second ST_RUN pass:
  - all outputs go to 0 immediately;
  - no `st_out_valid` pulse appears;
  - the next request completes correctly.
- Repeat the first two scenarios with LANES = 1, 2, 8, 16:
  - identical data results;
  - SubBytes latency 16/8/2/1 cycles;
  - SubWord latency 4/2/1/1 cycles.

Source files
------------

// File: rtl/sbox_share_ctrl.sv
// Shares a small bank of AES forward S-boxes between SubBytes (128b) and SubWord (32b) requesters.
// Latency: 16/LANES cycles for SubBytes, max(1, 4/LANES) for SubWord; one operation in flight.
// Backpressure: requests are taken only in IDLE (key word first); results hold until *_out_ready.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = TBL[a];
endmodule

module sbox_share_ctrl #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out_data,
    output logic         busy
);
    localparam int P_ST     = 16 / LANES;
    localparam int P_KW     = (LANES >= 4) ? 1 : 4 / LANES;
    localparam int CW       = (P_ST > 1) ? $clog2(P_ST) : 1;
    localparam int KW_LANES = (LANES > 4) ? 4 : LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
        $error("sbox_share_ctrl: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_RUN,
        S_KW_RUN,
        S_ST_HOLD,
        S_KW_HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [127:0]    op;
    logic [127:0]    res;
    logic            st_hs;
    logic            kw_hs;
    logic            last_pass;
    logic [3:0]      lane_idx [LANES];
    logic [7:0]      lane_in  [LANES];
    logic [7:0]      lane_out [LANES];

    assign st_hs     = st_valid & st_ready;
    assign kw_hs     = kw_valid & kw_ready;
    assign last_pass = (state == S_ST_RUN) ? (cnt == CW'(P_ST - 1)) : (cnt == CW'(P_KW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (kw_hs) begin
                    state_nxt = S_KW_RUN;
                end else if (st_hs) begin
                    state_nxt = S_ST_RUN;
                end
            end
            S_ST_RUN:  if (last_pass) state_nxt = S_ST_HOLD;
            S_KW_RUN:  if (last_pass) state_nxt = S_KW_HOLD;
            S_ST_HOLD: if (st_out_ready) state_nxt = S_IDLE;
            S_KW_HOLD: if (kw_out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The key word wins ties: a round cannot proceed without its key.
    always_comb begin
        st_ready     = 1'b0;
        kw_ready     = 1'b0;
        st_out_valid = 1'b0;
        kw_out_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            S_IDLE: begin
                kw_ready = 1'b1;
                st_ready = ~kw_valid;
                busy     = 1'b0;
            end
            S_ST_HOLD: st_out_valid = 1'b1;
            S_KW_HOLD: kw_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign st_out_data = res;
    assign kw_out_data = res[31:0];

    // Pass k maps operand byte k*LANES+l onto lane l; idle lanes see zero to keep them quiet.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(cnt) * LANES + l);
            if ((state == S_ST_RUN) || ((state == S_KW_RUN) && (l < KW_LANES))) begin
                lane_in[l] = op[{lane_idx[l], 3'b000} +: 8];
            end else begin
                lane_in[l] = 8'h00;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (
            .a (lane_in[g]),
            .y (lane_out[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            op  <= '0;
            res <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (kw_hs) begin
                        op  <= {96'h0, kw_data};
                        cnt <= '0;
                        res <= '0;
                    end else if (st_hs) begin
                        op  <= st_data;
                        cnt <= '0;
                        res <= '0;
                    end
                end
                S_ST_RUN, S_KW_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if ((state == S_ST_RUN) || (l < KW_LANES)) begin
                            res[{lane_idx[l], 3'b000} +: 8] <= lane_out[l];
                        end
                    end
                    cnt <= last_pass ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: five instances (LANES = 1,2,4,8,16) checked every cycle against a
// transaction-level model built on an algebraically derived S-box, plus directed literal checks.
module tb_sbox_share_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   st_valid, st_out_ready, kw_valid, kw_out_ready;
    logic [4:0]   st_ready, st_out_valid, kw_ready, kw_out_valid, busy;
    logic [127:0] st_data;
    logic [31:0]  kw_data;
    logic [127:0] st_out_data [5];
    logic [31:0]  kw_out_data [5];

    int checks   = 0;
    int failures = 0;

    logic [7:0]   ref_tbl [256];
    int           m_state [5];
    int           m_rem   [5];
    logic [127:0] m_res   [5];
    logic [4:0]   acc_st, acc_kw, oh_st, oh_kw;
    logic [4:0]   cmp_ev;

    int lat_st [5] = '{16, 8, 4, 2, 1};
    int lat_kw [5] = '{4, 2, 1, 1, 1};

    localparam logic [127:0] V_ST_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] V_ST_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sbox_share_ctrl #(.LANES(1 << g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .st_valid     (st_valid[g]),
            .st_ready     (st_ready[g]),
            .st_data      (st_data),
            .st_out_valid (st_out_valid[g]),
            .st_out_ready (st_out_ready[g]),
            .st_out_data  (st_out_data[g]),
            .kw_valid     (kw_valid[g]),
            .kw_ready     (kw_ready[g]),
            .kw_data      (kw_data),
            .kw_out_valid (kw_out_valid[g]),
            .kw_out_ready (kw_out_ready[g]),
            .kw_out_data  (kw_out_data[g]),
            .busy         (busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse in GF(2^8) followed by the AES affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_sub(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tbl[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] model_sw(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_tbl[w[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Model: idle -> run for P edges -> hold until out_ready; key word wins ties.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_state[i] <= 0;
                m_rem[i]   <= 0;
                m_res[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                case (m_state[i])
                    0: begin
                        if (kw_valid[i]) begin
                            m_state[i] <= 2;
                            m_rem[i]   <= ((4 >> i) == 0) ? 1 : (4 >> i);
                            m_res[i]   <= {96'h0, model_sw(kw_data)};
                        end else if (st_valid[i]) begin
                            m_state[i] <= 1;
                            m_rem[i]   <= 16 >> i;
                            m_res[i]   <= model_sub(st_data);
                        end
                    end
                    1, 2: begin
                        m_rem[i] <= m_rem[i] - 1;
                        if (m_rem[i] == 1) m_state[i] <= m_state[i] + 2;
                    end
                    3: if (st_out_ready[i]) m_state[i] <= 0;
                    4: if (kw_out_ready[i]) m_state[i] <= 0;
                    default: m_state[i] <= 0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        acc_st <= st_valid & st_ready;
        acc_kw <= kw_valid & kw_ready;
        oh_st  <= st_out_valid & st_out_ready;
        oh_kw  <= kw_out_valid & kw_out_ready;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            cmp_ev = {(m_state[i] == 0) && !kw_valid[i], m_state[i] == 0, m_state[i] == 3,
                      m_state[i] == 4, m_state[i] != 0};
            chk($sformatf("ctl L%0d {st_rdy,kw_rdy,st_ov,kw_ov,busy}", 1 << i),
                {st_ready[i], kw_ready[i], st_out_valid[i], kw_out_valid[i], busy[i]}, cmp_ev);
            if (rst) begin
                chk($sformatf("rst st_out_data L%0d", 1 << i), st_out_data[i], '0);
                chk($sformatf("rst kw_out_data L%0d", 1 << i), kw_out_data[i], '0);
            end else if (m_state[i] == 3) begin
                chk($sformatf("st_out_data L%0d", 1 << i), st_out_data[i], m_res[i]);
            end else if (m_state[i] == 4) begin
                chk($sformatf("kw_out_data L%0d", 1 << i), {96'h0, kw_out_data[i]}, m_res[i]);
            end
        end
    end

    // Called at posedge+1 with the instance idle; returns at posedge+1 after the output handshake.
    task automatic do_op(input int i, input bit kw, input logic [127:0] d,
                         input logic [127:0] exp, input int lat_exp);
        int lat;
        bit ok;
        string nm;
        nm = $sformatf("%s L%0d", kw ? "kw" : "st", 1 << i);
        if (kw) begin
            kw_data = d[31:0]; kw_valid[i] = 1'b1; kw_out_ready[i] = 1'b1;
        end else begin
            st_data = d; st_valid[i] = 1'b1; st_out_ready[i] = 1'b1;
        end
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (kw ? acc_kw[i] : acc_st[i]) begin ok = 1'b1; break; end
        end
        if (kw) kw_valid[i] = 1'b0; else st_valid[i] = 1'b0;
        chk({nm, " accepted"}, ok, 1'b1);
        lat = 0;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (kw ? kw_out_valid[i] : st_out_valid[i]) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " out_valid seen"}, ok, 1'b1);
        chk({nm, " latency"}, lat, lat_exp);
        chk({nm, " data"}, kw ? {96'h0, kw_out_data[i]} : st_out_data[i], exp);
        @(posedge clk); #1;
        chk({nm, " out handshake"}, kw ? oh_kw[i] : oh_st[i], 1'b1);
    endtask

    initial begin
        bit seen;
        st_valid = '0; kw_valid = '0; st_out_ready = '0; kw_out_ready = '0;
        st_data = '0; kw_data = '0;
        for (int a = 0; a < 256; a++) ref_tbl[a] = sbox_calc(8'(a));
        chk("model SubBytes vector", model_sub(V_ST_IN), V_ST_OUT);
        chk("model SubWord vector", model_sw(32'h09cf4f3c), 32'h018a84eb);
        chk("model S(53)", ref_tbl[8'h53], 8'hed);

        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl L4", {st_ready[2], kw_ready[2], st_out_valid[2], kw_out_valid[2], busy[2]}, 5'b11000);
        chk("reset st_out_data L4", st_out_data[2], '0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(2, 1'b0, V_ST_IN, V_ST_OUT, 4);
        do_op(2, 1'b1, {96'h0, 32'h09cf4f3c}, {96'h0, 32'h018a84eb}, 1);

        // Simultaneous requests: key word first, round waits for the KW hold to release.
        st_data = '0; kw_data = 32'h00000053;
        st_valid[2] = 1'b1; kw_valid[2] = 1'b1; st_out_ready[2] = 1'b1; kw_out_ready[2] = 1'b1;
        @(posedge clk); #1;
        chk("prio accept {kw,st}", {acc_kw[2], acc_st[2]}, 2'b10);
        kw_valid[2] = 1'b0;
        chk("prio st_ready in KW_RUN", st_ready[2], 1'b0);
        @(posedge clk); #1;
        chk("prio kw_out_valid", kw_out_valid[2], 1'b1);
        chk("prio kw result", kw_out_data[2], 32'h636363ed);
        chk("prio st_ready in KW_HOLD", st_ready[2], 1'b0);
        @(posedge clk); #1;
        chk("prio kw handshake", oh_kw[2], 1'b1);
        chk("prio st_ready after KW_HOLD", st_ready[2], 1'b1);
        @(posedge clk); #1;
        chk("prio st accepted", acc_st[2], 1'b1);
        st_valid[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("prio st_out_valid", st_out_valid[2], 1'b1);
        chk("prio st result", st_out_data[2], 128'h63636363636363636363636363636363);
        @(posedge clk); #1;

        // Output backpressure with a competing key-word request pending.
        st_out_ready[2] = 1'b0;
        st_data = {16{8'h53}};
        st_valid[2] = 1'b1;
        @(posedge clk); #1;
        chk("bp st accepted", acc_st[2], 1'b1);
        st_valid[2] = 1'b0;
        kw_data = 32'h0; kw_valid[2] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            seen = st_out_valid[2];
        end
        chk("bp out_valid seen", seen, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp held valid", st_out_valid[2], 1'b1);
            chk("bp held data", st_out_data[2], {16{8'hed}});
            chk("bp readies", {st_ready[2], kw_ready[2]}, 2'b00);
        end
        st_out_ready[2] = 1'b1;
        @(posedge clk); #1;
        chk("bp st handshake", oh_st[2], 1'b1);
        @(posedge clk); #1;
        chk("bp kw accepted after hold", acc_kw[2], 1'b1);
        kw_valid[2] = 1'b0;
        @(posedge clk); #1;
        chk("bp kw result", kw_out_data[2], 32'h63636363);
        @(posedge clk); #1;

        // Reset during the second SubBytes pass discards the operation.
        st_data = V_ST_IN; st_valid[2] = 1'b1;
        @(posedge clk); #1;
        chk("rst-mid accepted", acc_st[2], 1'b1);
        st_valid[2] = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst-mid ctl", {st_ready[2], kw_ready[2], st_out_valid[2], kw_out_valid[2], busy[2]}, 5'b11000);
        chk("rst-mid st_out_data", st_out_data[2], '0);
        chk("rst-mid kw_out_data", kw_out_data[2], '0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen = seen | st_out_valid[2];
        end
        chk("rst-mid no st_out_valid pulse", seen, 1'b0);
        do_op(2, 1'b0, V_ST_IN, V_ST_OUT, 4);

        for (int i = 0; i < 5; i++) begin
            if (i != 2) begin
                do_op(i, 1'b0, V_ST_IN, V_ST_OUT, lat_st[i]);
                do_op(i, 1'b1, {96'h0, 32'h09cf4f3c}, {96'h0, 32'h018a84eb}, lat_kw[i]);
            end
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
